// File: rtl/fluid_restock_controller.sv
// fluid_restock_controller
// Purpose : owns the water/juice/chemical stock registers, serves dispenser
//           withdrawals (result one cycle later) and refills any tank that
//           falls below LOW_MARK via a req/grant handshake with the pump.
// Latency : wd_done/wd_err are registered one cycle after wd_valid; supply_req
//           follows a low tank by one cycle (IDLE -> REQ).
// Backpressure: none on withdrawals (one per cycle); the pump throttles refill
//           through supply_grant, and filling pauses whenever grant is low.
// Ports   : clk/reset_n (async active-low); wd_valid/wd_type/wd_volume in,
//           wd_done/wd_err out; supply_req/supply_sel out, supply_grant in,
//           refill_done out; water_qty/juice_qty/chem_qty stock, low_flags.
module fluid_restock_controller #(
  parameter int unsigned WATER_CAP = 100,
  parameter int unsigned JUICE_CAP = 80,
  parameter int unsigned CHEM_CAP  = 60,
  parameter int unsigned LOW_MARK  = 20,
  parameter int unsigned FILL_RATE = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wd_valid,
  input  logic [1:0]  wd_type,
  input  logic [7:0]  wd_volume,
  output logic        wd_done,
  output logic        wd_err,
  output logic        supply_req,
  output logic [1:0]  supply_sel,
  input  logic        supply_grant,
  output logic        refill_done,
  output logic [15:0] water_qty,
  output logic [15:0] juice_qty,
  output logic [15:0] chem_qty,
  output logic [2:0]  low_flags
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Index 0 water, 1 juice, 2 chemical (matches wd_type and supply_sel codes).
  localparam logic [2:0][15:0] CAPS = {16'(CHEM_CAP), 16'(JUICE_CAP), 16'(WATER_CAP)};

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [2:0][15:0] qty_q, qty_d;
  logic             wd_done_q, wd_err_q;
  logic             wd_ok;
  logic [15:0]      wd_stock;
  logic [16:0]      fill_sum;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      low_flags[i] = (qty_q[i] < 16'(LOW_MARK));
    end
  end

  // Stock seen by the withdrawal check; the invalid code 11 never passes.
  always_comb begin
    wd_stock = 16'd0;
    case (wd_type)
      2'd0:    wd_stock = qty_q[0];
      2'd1:    wd_stock = qty_q[1];
      2'd2:    wd_stock = qty_q[2];
      default: wd_stock = 16'd0;
    endcase
  end

  assign wd_ok = wd_valid && (wd_type != 2'd3) && ({8'd0, wd_volume} <= wd_stock);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    qty_d    = qty_q;
    fill_sum = 17'd0;

    // Withdrawal first, so a same-tank fill adds on top of the decremented
    // value and the clamp applies to the combined result.
    for (int i = 0; i < 3; i++) begin
      if (wd_ok && (wd_type == 2'(i))) begin
        qty_d[i] = qty_q[i] - {8'd0, wd_volume};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|low_flags) begin
          // Fixed priority: water, then juice, then chemical.
          if (low_flags[0])      sel_d = 2'd0;
          else if (low_flags[1]) sel_d = 2'd1;
          else                   sel_d = 2'd2;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (supply_grant) state_d = S_FILL;
      end
      S_FILL: begin
        if (supply_grant) begin
          for (int i = 0; i < 3; i++) begin
            if (sel_q == 2'(i)) begin
              fill_sum = {1'b0, qty_d[i]} + 17'(FILL_RATE);
              if (fill_sum >= {1'b0, CAPS[i]}) qty_d[i] = CAPS[i];
              else                             qty_d[i] = fill_sum[15:0];
              // A concurrent withdrawal can keep us short of CAP; keep filling.
              if (qty_d[i] == CAPS[i]) state_d = S_DONE;
            end
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      qty_q     <= CAPS;
      wd_done_q <= 1'b0;
      wd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      qty_q     <= qty_d;
      wd_done_q <= wd_valid;
      wd_err_q  <= wd_valid && !wd_ok;
    end
  end

  // Decoded from the state register so reset drops them asynchronously.
  assign supply_req  = (state_q == S_REQ) || (state_q == S_FILL);
  assign refill_done = (state_q == S_DONE);
  assign supply_sel  = sel_q;
  assign wd_done     = wd_done_q;
  assign wd_err      = wd_err_q;
  assign water_qty   = qty_q[0];
  assign juice_qty   = qty_q[1];
  assign chem_qty    = qty_q[2];

endmodule

// File: tb/tb_fluid_restock_controller.sv
// Testbench for fluid_restock_controller: directed scenarios followed by
// random withdrawals and pump grants, checked against a tank-level model.
module tb_fluid_restock_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wd_valid;
  logic [1:0]  wd_type;
  logic [7:0]  wd_volume;
  logic        wd_done;
  logic        wd_err;
  logic        supply_req;
  logic [1:0]  supply_sel;
  logic        supply_grant;
  logic        refill_done;
  logic [15:0] water_qty;
  logic [15:0] juice_qty;
  logic [15:0] chem_qty;
  logic [2:0]  low_flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fluid_restock_controller dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wd_valid     (wd_valid),
    .wd_type      (wd_type),
    .wd_volume    (wd_volume),
    .wd_done      (wd_done),
    .wd_err       (wd_err),
    .supply_req   (supply_req),
    .supply_sel   (supply_sel),
    .supply_grant (supply_grant),
    .refill_done  (refill_done),
    .water_qty    (water_qty),
    .juice_qty    (juice_qty),
    .chem_qty     (chem_qty),
    .low_flags    (low_flags)
  );

  function automatic int cap(input int i);
    case (i)
      0:       return 100;
      1:       return 80;
      default: return 60;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tanks as plain integers. Refill bookkeeping: m_tgt is the tank awaiting or
  // receiving pump delivery (-1 when none), m_pump says delivery has started,
  // m_cool marks the single completion cycle.
  int m_qty[3];
  int m_tgt;
  int m_sel;
  bit m_pump;
  bit m_cool;
  bit exp_err_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++) m_qty[i] = cap(i);
      m_tgt  = -1;
      m_sel  = 0;
      m_pump = 0;
      m_cool = 0;
      exp_err_q.delete();
    end else begin
      int nq[3];
      int pick;
      bit ok;
      nq = m_qty;
      if (wd_valid) begin
        if (wd_type == 2'd3) ok = 0;
        else ok = int'(wd_volume) <= m_qty[int'(wd_type)];
        if (ok) nq[int'(wd_type)] = nq[int'(wd_type)] - int'(wd_volume);
        exp_err_q.push_back(!ok);
      end
      if (m_cool) begin
        m_cool = 0;
      end else if (m_tgt < 0) begin
        pick = -1;
        for (int i = 2; i >= 0; i--) if (m_qty[i] < 20) pick = i;
        if (pick >= 0) begin
          m_tgt  = pick;
          m_sel  = pick;
          m_pump = 0;
        end
      end else if (!m_pump) begin
        if (supply_grant) m_pump = 1;
      end else if (supply_grant) begin
        nq[m_tgt] = nq[m_tgt] + 5;
        if (nq[m_tgt] > cap(m_tgt)) nq[m_tgt] = cap(m_tgt);
        if (nq[m_tgt] == cap(m_tgt)) begin
          m_cool = 1;
          m_tgt  = -1;
          m_pump = 0;
        end
      end else begin
        m_pump = 0;
      end
      m_qty = nq;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      bit exp_done;
      bit exp_e;
      exp_done = (exp_err_q.size() > 0);
      chk("wd_done", 32'(wd_done), 32'(exp_done));
      if (exp_done) begin
        exp_e = exp_err_q.pop_front();
        if (wd_done) chk("wd_err", 32'(wd_err), 32'(exp_e));
      end
      chk("water_qty", 32'(water_qty), m_qty[0]);
      chk("juice_qty", 32'(juice_qty), m_qty[1]);
      chk("chem_qty", 32'(chem_qty), m_qty[2]);
      chk("low_flags", 32'(low_flags),
          {29'd0, m_qty[2] < 20, m_qty[1] < 20, m_qty[0] < 20});
      chk("supply_req", 32'(supply_req), 32'(m_tgt >= 0));
      chk("supply_sel", 32'(supply_sel), m_sel);
      chk("refill_done", 32'(refill_done), 32'(m_cool));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit [1:0] t, input bit [7:0] vol, input bit g);
    @(negedge clk);
    wd_valid     = v;
    wd_type      = t;
    wd_volume    = vol;
    supply_grant = g;
  endtask

  task automatic wait_refill(input string name, input int budget);
    bit found;
    found = 0;
    for (int k = 0; k < budget; k++) begin
      drive(0, 2'd0, 8'd0, 1);
      if (refill_done) begin
        found = 1;
        break;
      end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  // Hold grant until water reaches the target, observing before driving.
  task automatic fill_water_to(input string name, input int target);
    bit hit;
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (int'(water_qty) >= target) begin
        hit = 1;
        break;
      end
      wd_valid     = 0;
      supply_grant = 1;
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    reset_n      = 1'b0;
    wd_valid     = 0;
    wd_type      = 2'd0;
    wd_volume    = 8'd0;
    supply_grant = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("rst_water", 32'(water_qty), 32'd100);
    chk("rst_juice", 32'(juice_qty), 32'd80);
    chk("rst_chem", 32'(chem_qty), 32'd60);
    chk("rst_low", 32'(low_flags), 32'd0);
    chk("rst_req", 32'(supply_req), 32'd0);
    chk("rst_done", 32'(wd_done), 32'd0);

    // Water 85 withdrawn, then a full refill with grant held.
    drive(1, 2'd0, 8'd85, 0);
    drive(0, 2'd0, 8'd0, 0);
    chk("w85_qty", 32'(water_qty), 32'd15);
    chk("w85_low0", 32'(low_flags[0]), 32'd1);
    drive(0, 2'd0, 8'd0, 0);
    chk("w85_req", 32'(supply_req), 32'd1);
    chk("w85_sel", 32'(supply_sel), 32'd0);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      drive(0, 2'd0, 8'd0, 1);
      if (refill_done) pulses++;
    end
    chk("w85_pulses", 32'(pulses), 32'd1);
    chk("w85_full", 32'(water_qty), 32'd100);

    // Insufficient stock and invalid type.
    drive(1, 2'd1, 8'd81, 0);
    drive(1, 2'd3, 8'd1, 0);
    chk("j81_err", 32'(wd_err), 32'd1);
    drive(0, 2'd0, 8'd0, 0);
    chk("type3_err", 32'(wd_err), 32'd1);
    chk("j81_qty", 32'(juice_qty), 32'd80);

    // Two low tanks: water refilled before juice.
    drive(1, 2'd0, 8'd90, 0);
    drive(1, 2'd1, 8'd75, 0);
    drive(0, 2'd0, 8'd0, 1);
    chk("prio_req", 32'(supply_req), 32'd1);
    chk("prio_sel0", 32'(supply_sel), 32'd0);
    wait_refill("prio_water_done", 40);
    drive(0, 2'd0, 8'd0, 1);
    drive(0, 2'd0, 8'd0, 1);
    chk("prio_sel1", 32'(supply_sel), 32'd1);
    chk("prio_req1", 32'(supply_req), 32'd1);
    wait_refill("prio_juice_done", 40);
    chk("prio_juice_full", 32'(juice_qty), 32'd80);

    // Grant dropped for 3 cycles at water 50.
    drive(1, 2'd0, 8'd85, 0);
    fill_water_to("reach50", 50);
    supply_grant = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 2'd0, 8'd0, 0);
      chk("hold_qty", 32'(water_qty), 32'd50);
      chk("hold_req", 32'(supply_req), 32'd1);
      chk("hold_sel", 32'(supply_sel), 32'd0);
    end
    wait_refill("resume_done", 30);

    // Same-tank withdrawal and fill at 98: clamps to 100 and completes.
    drive(1, 2'd0, 8'd82, 0);
    fill_water_to("reach98", 98);
    wd_valid     = 1;
    wd_type      = 2'd0;
    wd_volume    = 8'd3;
    supply_grant = 1;
    drive(0, 2'd0, 8'd0, 1);
    chk("clamp_err", 32'(wd_err), 32'd0);
    chk("clamp_qty", 32'(water_qty), 32'd100);
    chk("clamp_done", 32'(refill_done), 32'd1);
    drive(0, 2'd0, 8'd0, 0);

    // Asynchronous reset in the middle of a fill.
    drive(1, 2'd0, 8'd85, 0);
    repeat (6) drive(0, 2'd0, 8'd0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(supply_req), 32'd0);
    chk("arst_water", 32'(water_qty), 32'd100);
    chk("arst_juice", 32'(juice_qty), 32'd80);
    chk("arst_chem", 32'(chem_qty), 32'd60);
    chk("arst_wd_done", 32'(wd_done), 32'd0);
    supply_grant = 0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    drive(0, 2'd0, 8'd0, 0);
    drive(0, 2'd0, 8'd0, 0);
    chk("post_rst_req", 32'(supply_req), 32'd0);

    // Random traffic.
    repeat (3000) begin
      @(negedge clk);
      wd_valid     = ($urandom_range(0, 9) < 4);
      wd_type      = 2'($urandom_range(0, 3));
      wd_volume    = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                 : 8'($urandom_range(0, 30));
      supply_grant = ($urandom_range(0, 3) != 0);
    end
    repeat (3) drive(0, 2'd0, 8'd0, 0);
    chk("sb_drained", 32'(exp_err_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fluid_restock_controller.md
Name: fluid_restock_controller

Overview:
- Owns the stock registers for the three dispenser fluids: water, juice and chemical.
- Serves withdrawal requests from the dispenser side and reports the result one cycle later.
- Refills any tank that drops below a low-water mark through a request/grant handshake with the supply pump.
- Provides the stock-writer end of the dispenser stock interface, so dispenser logic no longer keeps stock itself.

Parameters:
- WATER_CAP, 100, water tank capacity in litres; also the water reset level.
- JUICE_CAP, 80, juice tank capacity in litres; also the juice reset level.
- CHEM_CAP, 60, chemical tank capacity in litres; also the chemical reset level.
- LOW_MARK, 20, a tank with stock strictly below this value needs a refill.
- FILL_RATE, 5, litres added per cycle while filling with grant high.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wd_valid  input  1  withdrawal request, sampled every cycle; no backpressure.
- wd_type  input  2  fluid code: 00 water, 01 juice, 10 chemical, 11 invalid.
- wd_volume  input  8  litres requested.
- wd_done  output  1  one-cycle pulse, one cycle after an accepted wd_valid.
- wd_err  output  1  valid with wd_done; 1 means insufficient stock or invalid type.
- supply_req  output  1  refill request to the pump.
- supply_sel  output  2  tank being refilled; held stable while supply_req=1.
- supply_grant  input  1  pump is delivering while high.
- refill_done  output  1  one-cycle pulse when the selected tank reaches capacity.
- water_qty, juice_qty, chem_qty  output  16 each  current registered stock.
- low_flags  output  3  bit0 water, bit1 juice, bit2 chemical; combinational (qty < LOW_MARK).

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Each qty is set to its CAP value.
  - FSM goes to IDLE.
  - wd_done, wd_err, supply_req, refill_done are 0; supply_sel is 00.
- Reset mid-operation aborts any fill, drops supply_req immediately, and discards any pending wd_done.
- Withdrawal:
  - On a cycle with wd_valid=1, the check is wd_volume <= qty[wd_type], using the registered qty at that edge.
  - If the check passes, qty is decremented at that edge. If it fails, or the type is 11, qty is unchanged and wd_err=1.
  - wd_done/wd_err are registered and appear the following cycle.
  - Back-to-back withdrawals are allowed, one per cycle.
  - A volume of 0 succeeds and leaves qty unchanged.
- Selection: the tank to refill is the lowest-index tank whose low_flags bit is set (water > juice > chemical).
- FSM:
  - IDLE: if any low_flags bit is 1, latch supply_sel and go to REQ.
  - REQ: supply_req=1. Go to FILL on supply_grant=1.
  - FILL: supply_req=1. On each cycle with grant=1, qty[sel] += FILL_RATE, saturating at CAP. If grant drops, go back to REQ with the same sel. When the post-update qty equals CAP, go to DONE.
  - DONE: refill_done=1 and supply_req=0 for one cycle, then IDLE.
- Simultaneous withdrawal and fill on the same tank in one cycle:
  - Pass/fail is judged on the pre-edge qty.
  - next = min(qty - (ok ? vol : 0) + FILL_RATE, CAP).
  - If that result is below CAP, the FSM stays in FILL.
- A withdrawal on another tank during FILL is handled normally. A tank that goes low meanwhile waits for the next IDLE.
- Arithmetic:
  - Internal sums are 17 bits wide, then clamped to CAP.
  - Stock never wraps below 0, because failed checks cause no decrement.
- Worst-case refill latency from IDLE: 1 cycle to REQ, plus grant wait, plus ceil((CAP-qty)/FILL_RATE) fill cycles, plus 1 DONE cycle.

Test Plan:
- Reset release -> water_qty=100, juice_qty=80, chem_qty=60; low_flags=000; supply_req=0; wd_done=0.
- Withdraw water 85 -> next cycle wd_done=1, wd_err=0, water_qty=15, low_flags[0]=1. Next cycle: REQ, supply_req=1, supply_sel=00. Hold grant=1 -> 17 fill cycles to 100, then refill_done pulses once and the FSM returns to IDLE.
- Juice at 80, withdraw 81 -> wd_err=1, juice_qty stays 80. wd_type=11 with volume 1 -> wd_err=1, no qty change.
- Bring water to 10 and juice to 5 in the same idle window -> water is refilled first (supply_sel=00). After refill_done, supply_sel=01 and juice fills to 80.
- During a water fill at qty 50, drop grant for 3 cycles -> qty holds at 50, FSM is in REQ with supply_req=1 and supply_sel=00; filling resumes when grant returns.
- At water qty 98 in FILL with grant=1, withdraw 3 in the same cycle -> wd_err=0 and water_qty=100 (clamped), DONE follows. Separately, assert reset_n=0 mid-fill -> all qty return to CAP and supply_req drops asynchronously.
